// File: rtl/alu_control_unit.sv
// Multi-cycle instruction sequencer for the registered 16-bit ALU: fetch, decode, execute, write-back.
// Optional multiply decode is enabled by defining ALU_CTRL_MUL_EN.
module alu_control_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic              z_flag,
    output logic [2:0]        alu_sel,
    output logic [3:0]        reg_sel,
    output logic              acc_ld,
    output logic              reg_ld,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
`ifdef ALU_CTRL_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'h2;
`endif
    localparam logic [3:0] OP_MOVA = 4'h3;
    localparam logic [3:0] OP_MOVB = 4'h4;
    localparam logic [3:0] OP_STR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'b100;

    function automatic logic op_is_alu(input logic [3:0] op);
`ifdef ALU_CTRL_MUL_EN
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_MOVA) || (op == OP_MOVB);
`else
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_MOVA) || (op == OP_MOVB);
`endif
    endfunction

    function automatic logic op_is_defined(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_STR) || (op == OP_JMP) ||
               (op == OP_JZ) || (op == OP_JNZ) || (op == OP_HALT);
    endfunction

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic                r_zr;
    logic                r_imem_req;
    logic [2:0]          r_alu_sel;
    logic                r_acc_ld;
    logic                r_reg_ld;
    logic                r_halted;
    logic                r_illegal;

    state_t              w_state_next;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [15:0]         w_ir_next;
    logic                w_zr_next;
    logic [3:0]          w_op;
    logic [3:0]          w_op_next;
    logic [ADDR_W-1:0]   w_target;

    assign w_op      = r_ir[15:12];
    assign w_target  = r_ir[ADDR_W-1:0];
    assign w_op_next = w_ir_next[15:12];

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_zr_next    = r_zr;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_ir_next    = imem_data;
                    w_pc_next    = r_pc + ADDR_W'(1);
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_is_alu(w_op) || (w_op == OP_STR)) begin
                    w_state_next = S_EXEC;
                end else if (w_op == OP_HALT) begin
                    w_state_next = S_HALT;
                end else begin
                    // Jumps resolve here so the target is fetched next cycle; undefined ops fall through as NOP.
                    if ((w_op == OP_JMP) || ((w_op == OP_JZ) && r_zr) ||
                        ((w_op == OP_JNZ) && !r_zr)) begin
                        w_pc_next = w_target;
                    end
                    w_state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                w_state_next = (w_op == OP_STR) ? S_FETCH : S_WB;
            end
            S_WB: begin
                if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                    w_zr_next = z_flag;
                end
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_zr       <= 1'b0;
            r_imem_req <= 1'b1;
            r_alu_sel  <= ALU_PASS_B;
            r_acc_ld   <= 1'b0;
            r_reg_ld   <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_zr       <= w_zr_next;
            r_imem_req <= (w_state_next == S_FETCH);
            r_alu_sel  <= ((w_state_next == S_EXEC) && op_is_alu(w_op_next)) ?
                          w_ir_next[14:12] : ALU_PASS_B;
            r_acc_ld   <= (w_state_next == S_WB);
            r_reg_ld   <= (w_state_next == S_EXEC) && (w_op_next == OP_STR);
            r_halted   <= (w_state_next == S_HALT);
            r_illegal  <= (w_state_next == S_DECODE) && !op_is_defined(w_op_next);
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign reg_sel   = r_ir[11:8];
    assign alu_sel   = r_alu_sel;
    assign acc_ld    = r_acc_ld;
    assign reg_ld    = r_reg_ld;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_alu_control_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        z_flag;
    logic [2:0]  alu_sel;
    logic [3:0]  reg_sel;
    logic        acc_ld;
    logic        reg_ld;
    logic        halted;
    logic        illegal;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: architectural PC and zero register.
    logic [7:0] m_pc;
    bit         m_zr;

    alu_control_unit #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .z_flag    (z_flag),
        .alu_sel   (alu_sel),
        .reg_sel   (reg_sel),
        .acc_ld    (acc_ld),
        .reg_ld    (reg_ld),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_outs(input string tag, input bit req, input logic [2:0] alu,
                               input bit acc, input bit rld, input bit hlt, input bit ill);
        check(tag, {24'd0, imem_req, alu_sel, acc_ld, reg_ld, halted, illegal},
                   {24'd0, req, alu, acc, rld, hlt, ill});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic bit ref_alu(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h3, 4'h4: return 1'b1;
`ifdef ALU_CTRL_MUL_EN
            4'h2: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_defined(input logic [3:0] op);
        return ref_alu(op) || (op == 4'h5) || (op == 4'h8) || (op == 4'h9) ||
               (op == 4'hA) || (op == 4'hF);
    endfunction

    // One whole instruction: waits, ack, then each following cycle checked against the model.
    task automatic do_instr(input logic [15:0] ins, input int waits, input bit zf);
        logic [3:0] op;
        op = ins[15:12];
        for (int w = 0; w < waits; w++) begin
            expect_outs("fetch_wait", 1, 3'b100, 0, 0, 0, 0);
            check("addr_wait", 32'(imem_addr), 32'(m_pc));
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            step();
        end
        expect_outs("fetch", 1, 3'b100, 0, 0, 0, 0);
        check("addr", 32'(imem_addr), 32'(m_pc));
        imem_ack  = 1'b1;
        imem_data = ins;
        step();
        m_pc = m_pc + 8'd1;
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 16'($urandom);
        expect_outs("decode", 0, 3'b100, 0, 0, 0, !ref_defined(op));
        check("reg_sel", 32'(reg_sel), 32'(ins[11:8]));
        if ((op == 4'h8) || ((op == 4'h9) && m_zr) || ((op == 4'hA) && !m_zr))
            m_pc = ins[7:0];
        if (ref_alu(op)) begin
            step();
            imem_ack = 1'($urandom_range(0, 1));
            z_flag   = ~zf;
            expect_outs("exec", 0, ins[14:12], 0, 0, 0, 0);
            step();
            z_flag = zf;
            expect_outs("wb", 0, 3'b100, 1, 0, 0, 0);
            if (op <= 4'h1) m_zr = zf;
            step();
            z_flag = 1'($urandom_range(0, 1));
        end else if (op == 4'h5) begin
            step();
            expect_outs("str", 0, 3'b100, 0, 1, 0, 0);
            step();
        end else if (op == 4'hF) begin
            for (int h = 0; h < 4; h++) begin
                step();
                imem_ack = 1'($urandom_range(0, 1));
                expect_outs("halt", 0, 3'b100, 0, 0, 1, 0);
            end
        end else begin
            step();
        end
        imem_ack = 1'b0;
        $display("instr %04h waits %0d zf %0d -> next pc %02h zr %0d", ins, waits, zf, m_pc, m_zr);
    endtask

    // One-cycle reset with an ack asserted alongside it; reset must win.
    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'h8855;
        step();
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        m_pc = 8'd0;
        m_zr = 1'b0;
        expect_outs(tag, 1, 3'b100, 0, 0, 0, 0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_regsel"}, 32'(reg_sel), 32'd0);
        $display("reset %s", tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        z_flag    = 1'b0;
        m_pc      = 8'd0;
        m_zr      = 1'b0;
        repeat (3) step();
        expect_outs("reset", 1, 3'b100, 0, 0, 0, 0);
        check("reset_addr", 32'(imem_addr), 32'd0);
        check("reset_regsel", 32'(reg_sel), 32'd0);
        rst_n = 1'b1;

        do_instr(16'h0100, 0, 1'b0);      // ADD R1
        do_instr(16'h1200, 0, 1'b1);      // SUB R2, zero result
        do_instr(16'h9040, 0, 1'b0);      // JZ 0x40 taken
        do_instr(16'h1200, 0, 1'b1);      // SUB R2, zero result
        do_instr(16'hA040, 0, 1'b0);      // JNZ not taken
        do_instr(16'h0300, 3, 1'b0);      // ADD with 3 wait cycles
        do_instr(16'h3400, 1, 1'b1);      // MOVA leaves zr alone
        do_instr(16'h9010, 0, 1'b0);      // JZ not taken (zr=0)
        do_instr(16'h5600, 2, 1'b0);      // STR R6
        do_instr(16'h80FF, 0, 1'b0);      // JMP 0xFF
        do_instr(16'h7000, 0, 1'b0);      // undefined at 0xFF, PC wraps
        do_instr(16'h2300, 0, 1'b0);      // MUL (illegal unless enabled)
        do_instr(16'h4000, 0, 1'b0);      // MOVB

        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            do_instr({op, 12'($urandom)}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset mid-fetch while the word is still withheld.
        step();
        do_reset("rst_fetch");

        // Zero register must clear on reset.
        do_instr(16'h1100, 0, 1'b1);
        do_reset("rst_zr");
        do_instr(16'h9033, 0, 1'b0);

        // Reset in WB discards the in-flight ADD.
        check("wb_fetch_addr", 32'(imem_addr), 32'(m_pc));
        imem_ack  = 1'b1;
        imem_data = 16'h0300;
        step();
        imem_ack = 1'b0;
        step();
        step();
        expect_outs("pre_rst_wb", 0, 3'b100, 1, 0, 0, 0);
        do_reset("rst_wb");

        // HALT is absorbing until reset.
        do_instr(16'hF000, 0, 1'b0);
        for (int h = 0; h < 3; h++) begin
            imem_ack = 1'b1;
            step();
            expect_outs("halt_hold", 0, 3'b100, 0, 0, 1, 0);
        end
        do_reset("rst_halt");
        do_instr(16'h0500, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
